// File: rtl/audio_voice_mixer.sv
// Multi-voice sample player: time-multiplexes one sample-memory read port across
// VOICES voices and sums the active ones with signed saturation per sample_tick.
module audio_voice_mixer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int VOICES = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       sample_tick,
    input  logic [VOICES-1:0]          play,
    input  logic [VOICES-1:0]          stop,
    input  logic [VOICES-1:0]          loop,
    input  logic [VOICES*ADDR_W-1:0]   voice_base,
    input  logic [VOICES*ADDR_W-1:0]   voice_len,
    output logic [ADDR_W-1:0]          sound_address,
    input  logic [DATA_W-1:0]          sound_data,
    output logic [DATA_W-1:0]          sample_out,
    output logic                       sample_valid,
    output logic [VOICES-1:0]          playing,
    output logic [VOICES-1:0]          done,
    output logic                       busy,
    output logic                       tick_overrun
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW = DATA_W + 3;
    localparam logic [VW-1:0] LAST = VW'(VOICES - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {4'b1111, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state;
    logic [VW-1:0]          v;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   term;
    logic [ADDR_W-1:0]      offset [VOICES];
    logic [VOICES-1:0]      pend_play;
    logic [VOICES-1:0]      pend_stop;
    logic [VOICES-1:0]      eff_play;
    logic [VOICES-1:0]      eff_stop;
    logic [VOICES-1:0]      start;
    logic [VW-1:0]          data_voice;
    logic [VW-1:0]          addr_voice;
    logic                   data_en;
    logic                   data_play;
    logic [ADDR_W-1:0]      addr_off;
    logic [ADDR_W-1:0]      addr_next;
    logic [ADDR_W-1:0]      data_len;
    logic [DATA_W-1:0]      sat_out;

    always_comb begin
        eff_play = pend_play | play;
        eff_stop = pend_stop | stop;
        start    = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            start[i] = eff_play[i] & ~eff_stop[i] & (voice_len[i*ADDR_W +: ADDR_W] != '0);
        end

        // Read data lags the address by one cycle, so FETCH slot v carries voice v-1's data.
        data_en    = ((state == FETCH) && (v != '0)) || (state == DRAIN);
        data_voice = (state == DRAIN) ? LAST : v - VW'(1);
        data_play  = data_en & playing[data_voice];
        data_len   = voice_len[data_voice*ADDR_W +: ADDR_W];
        term       = data_play ? {{3{sound_data[DATA_W-1]}}, sound_data} : '0;
        acc_next   = acc + term;

        if (acc_next > SAT_MAX)      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
        else if (acc_next < SAT_MIN) sat_out = {1'b1, {(DATA_W-1){1'b0}}};
        else                         sat_out = acc_next[DATA_W-1:0];

        // A play applied in the tick cycle must already be reflected in voice 0's address.
        addr_voice = (state == IDLE) ? '0 : v + VW'(1);
        addr_off   = ((state == IDLE) && start[0]) ? '0 : offset[addr_voice];
        addr_next  = voice_base[addr_voice*ADDR_W +: ADDR_W] + addr_off;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            v             <= '0;
            acc           <= '0;
            sound_address <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            playing       <= '0;
            done          <= '0;
            busy          <= 1'b0;
            tick_overrun  <= 1'b0;
            pend_play     <= '0;
            pend_stop     <= '0;
            for (int unsigned i = 0; i < VOICES; i++) offset[i] <= '0;
        end else begin
            sample_valid <= 1'b0;
            done         <= '0;
            if (sample_tick && state != IDLE) tick_overrun <= 1'b1;

            if (state == IDLE) begin
                pend_play <= '0;
                pend_stop <= '0;
                for (int unsigned i = 0; i < VOICES; i++) begin
                    if (eff_stop[i]) begin
                        playing[i] <= 1'b0;
                    end else if (start[i]) begin
                        playing[i] <= 1'b1;
                        offset[i]  <= '0;
                    end
                end
            end else begin
                pend_play <= eff_play;
                pend_stop <= eff_stop;
            end

            if (data_play) begin
                if (offset[data_voice] == data_len - ADDR_W'(1)) begin
                    offset[data_voice] <= '0;
                    if (!loop[data_voice]) begin
                        playing[data_voice] <= 1'b0;
                        done[data_voice]    <= 1'b1;
                    end
                end else begin
                    offset[data_voice] <= offset[data_voice] + ADDR_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state         <= FETCH;
                        v             <= '0;
                        acc           <= '0;
                        busy          <= 1'b1;
                        sound_address <= addr_next;
                    end
                end
                FETCH: begin
                    acc <= acc_next;
                    if (v == LAST) begin
                        state <= DRAIN;
                    end else begin
                        v             <= v + VW'(1);
                        sound_address <= addr_next;
                    end
                end
                DRAIN: begin
                    sample_out   <= sat_out;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Directed bench for audio_voice_mixer with a one-cycle-latency sample memory model.
module tb_audio_voice_mixer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sample_tick;
    logic [3:0]  play, stop, loop;
    logic [39:0] voice_base, voice_len;
    logic [9:0]  sound_address;
    logic [15:0] sound_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [3:0]  playing, done;
    logic        busy, tick_overrun;

    logic [15:0] mem [1024];
    int total = 0;
    int bad = 0;

    audio_voice_mixer #(.ADDR_W(10), .DATA_W(16), .VOICES(4)) dut (
        .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick),
        .play(play), .stop(stop), .loop(loop),
        .voice_base(voice_base), .voice_len(voice_len),
        .sound_address(sound_address), .sound_data(sound_data),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .playing(playing), .done(done), .busy(busy), .tick_overrun(tick_overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) sound_data <= mem[sound_address];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick, then collect the frame's result, done pulses and voice-0 address.
    task automatic run_frame(output logic [15:0] s, output logic [3:0] d,
                             output logic [9:0] a0, output int lat);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        a0  = sound_address;
        d   = '0;
        lat = 1;
        while (!sample_valid && lat < 20) begin
            d |= done;
            step();
            lat++;
        end
        d |= done;
        s = sample_out;
        chk("frame_valid", {31'd0, sample_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        logic [3:0]  d;
        logic [9:0]  a0;
        int          lat;
        int          vcnt;
        logic [15:0] exp_end [4];
        logic [15:0] exp_loop [5];
        logic [9:0]  exp_wrap [4];

        exp_end  = '{16'd100, 16'd101, 16'd102, 16'd0};
        exp_loop = '{16'd10, 16'd11, 16'd10, 16'd11, 16'd10};
        exp_wrap = '{10'd1022, 10'd1023, 10'd0, 10'd1};

        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        Reset = 1'b1; sample_tick = 1'b0;
        play = '0; stop = '0; loop = '0;
        voice_base = '0; voice_len = '0;
        step(); step();

        chk("rst_addr",    {22'd0, sound_address}, 32'd0);
        chk("rst_sample",  {16'd0, sample_out}, 32'd0);
        chk("rst_status",  {22'd0, playing, done, busy, tick_overrun}, 32'd0);
        chk("rst_valid",   {31'd0, sample_valid}, 32'd0);
        Reset = 1'b0;
        step();

        // Single voice plays to the end of its region.
        voice_base[0 +: 10] = 10'd100;
        voice_len[0 +: 10]  = 10'd3;
        play = 4'b0001; step(); play = '0;
        chk("end_playing_start", {28'd0, playing}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            run_frame(s, d, a0, lat);
            chk($sformatf("end_sample%0d", k), {16'd0, s}, {16'd0, exp_end[k]});
            chk($sformatf("end_done%0d", k), {31'd0, d[0]}, (k == 2) ? 32'd1 : 32'd0);
        end
        chk("end_playing_after", {28'd0, playing}, 32'h0);

        // Looping voice never signals done.
        voice_base[10 +: 10] = 10'd10;
        voice_len[10 +: 10]  = 10'd2;
        loop = 4'b0010;
        play = 4'b0010; step(); play = '0;
        for (int k = 0; k < 5; k++) begin
            run_frame(s, d, a0, lat);
            chk($sformatf("loop_sample%0d", k), {16'd0, s}, {16'd0, exp_loop[k]});
            chk($sformatf("loop_done%0d", k), {28'd0, d}, 32'd0);
        end
        stop = 4'b0010; step(); stop = '0;
        chk("loop_stopped", {28'd0, playing}, 32'h0);

        // Saturation with four single-sample looping voices.
        voice_base = {10'd500, 10'd400, 10'd300, 10'd200};
        voice_len  = {10'd1, 10'd1, 10'd1, 10'd1};
        loop = 4'hF;
        mem[200] = 16'h7000; mem[300] = 16'h7000; mem[400] = 16'h7000; mem[500] = 16'h7000;
        play = 4'hF; step(); play = '0;
        run_frame(s, d, a0, lat);
        chk("sat_pos", {16'd0, s}, 32'h7FFF);
        mem[200] = 16'h9000; mem[300] = 16'h9000; mem[400] = 16'h9000; mem[500] = 16'h9000;
        run_frame(s, d, a0, lat);
        chk("sat_neg", {16'd0, s}, 32'h8000);
        mem[200] = 16'd5; mem[300] = 16'hFFFD; mem[400] = 16'd0; mem[500] = 16'd0;
        run_frame(s, d, a0, lat);
        chk("sat_mixed", {16'd0, s}, 32'h0002);
        stop = 4'hF; step(); stop = '0;
        loop = '0;
        chk("sat_stopped", {28'd0, playing}, 32'h0);

        // Latency with legal spacing, then overrun with spacing 4.
        chk("ovr_clear", {31'd0, tick_overrun}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            sample_tick = 1'b1; step(); sample_tick = 1'b0;
            chk($sformatf("lat_busy%0d", k), {31'd0, busy}, 32'd1);
            lat = 1;
            while (!sample_valid && lat < 20) begin step(); lat++; end
            chk($sformatf("lat_cycles%0d", k), lat, 32'd6);
            step();
        end
        chk("ovr_none", {31'd0, tick_overrun}, 32'd0);
        vcnt = 0;
        for (int c = 0; c < 24; c++) begin
            sample_tick = (c < 16) && (c % 4 == 0);
            step();
            if (sample_valid) vcnt++;
        end
        sample_tick = 1'b0;
        chk("ovr_valid_count", vcnt, 32'd2);
        chk("ovr_flag", {31'd0, tick_overrun}, 32'd1);

        // Commands: simultaneous play/stop, mid-frame play, zero length.
        voice_base[20 +: 10] = 10'd50;
        voice_len[20 +: 10]  = 10'd5;
        voice_len[30 +: 10]  = 10'd0;
        play = 4'b0100; stop = 4'b0100; step(); play = '0; stop = '0;
        chk("cmd_both", {28'd0, playing}, 32'h0);
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        step();
        play = 4'b0100; step(); play = '0;
        chk("cmd_mid_idle", {31'd0, playing[2]}, 32'd0);
        lat = 3;
        while (!sample_valid && lat < 20) begin step(); lat++; end
        chk("cmd_mid_sample", {16'd0, sample_out}, 32'd0);
        chk("cmd_mid_busy", {31'd0, busy}, 32'd0);
        step();
        chk("cmd_mid_active", {31'd0, playing[2]}, 32'd1);
        run_frame(s, d, a0, lat);
        chk("cmd_mid_first", {16'd0, s}, 32'd50);
        play = 4'b1000; step(); play = '0;
        chk("cmd_len0", {31'd0, playing[3]}, 32'd0);

        // Reset in the middle of a frame.
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        step(); step();
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("rmid_addr",   {22'd0, sound_address}, 32'd0);
        chk("rmid_sample", {16'd0, sample_out}, 32'd0);
        chk("rmid_status", {22'd0, playing, done, busy, tick_overrun}, 32'd0);
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (sample_valid) vcnt++;
            step();
        end
        chk("rmid_no_valid", vcnt, 32'd0);

        // Address wrap at the top of the memory.
        voice_base = '0; voice_len = '0;
        voice_base[0 +: 10] = 10'd1022;
        voice_len[0 +: 10]  = 10'd4;
        loop = 4'b0001;
        play = 4'b0001; step(); play = '0;
        for (int k = 0; k < 4; k++) begin
            run_frame(s, d, a0, lat);
            chk($sformatf("wrap_addr%0d", k), {22'd0, a0}, {22'd0, exp_wrap[k]});
            chk($sformatf("wrap_sample%0d", k), {16'd0, s}, {22'd0, exp_wrap[k]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
